game_controller: RTL
====================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5: points needed to win; legal range 1..7.
REQ-002 SHALL have parameter PAUSE_FRAMES, default 60: frame_tick count spent in POINT; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: master clock (50 MHz).
REQ-004 SHALL have port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: debounced start button level, synchronous to clk.
REQ-006 SHALL have port goal_p1, input, 1 bit: ball passed player 2's edge, so player 1 scores; level, synchronous.
REQ-007 SHALL have port goal_p2, input, 1 bit: ball passed player 1's edge, so player 2 scores; level, synchronous.
REQ-008 SHALL have port frame_tick, input, 1 bit: one-clk pulse per VGA frame.
REQ-009 SHALL have port score_1, output, 3 bits: player 1 score, to score_display p1.
REQ-010 SHALL have port score_2, output, 3 bits: player 2 score, to score_display p2.
REQ-011 SHALL have port cur_state, output, 2 bits: state code, to the VGA controller.
REQ-012 SHALL have port ball_reset, output, 1 bit: one-clk pulse that re-centres the ball.
REQ-013 SHALL have port serve_dir, output, 1 bit: 0 = serve toward player 1, 1 = serve toward player 2.
REQ-014 SHALL have port winner, output, 1 bit: 0 = player 1, 1 = player 2; valid only in OVER.

Function
REQ-015 SHALL register start, goal_p1 and goal_p2 once; an event is the rising edge (input high, registered copy low).
REQ-016 SHALL act on each event at the same clk edge that first samples the input high; all outputs are registered.
REQ-017 SHALL implement states SPLASH=00, PLAY=01, POINT=10, OVER=11, driven directly on cur_state.
REQ-018 In SPLASH: scores held at 0; a start event moves to PLAY and pulses ball_reset for one cycle.
REQ-019 In PLAY, a goal_p1 event alone: score_1 += 1 and serve_dir = 1.
REQ-020 In PLAY, a goal_p2 event alone: score_2 += 1 and serve_dir = 0.
REQ-021 In PLAY, after a scoring event: if the new score equals WIN_SCORE, move to OVER and set winner; otherwise move to POINT and clear the pause counter.
REQ-022 In PLAY, goal_p1 and goal_p2 events in the same cycle: neither score changes, serve_dir is unchanged, move to POINT.
REQ-023 In PLAY, start events are ignored.
REQ-024 In POINT: count frame_tick pulses in an 8-bit counter; a tick coincident with entry into POINT is not counted.
REQ-025 In POINT, when the count reaches PAUSE_FRAMES: move to PLAY and pulse ball_reset in the same cycle.
REQ-026 In POINT, goal and start events are ignored.
REQ-027 In OVER: scores and winner are held; a start event moves to SPLASH and clears both scores and winner in that cycle.
REQ-028 Scores SHALL never exceed WIN_SCORE and never wrap.
REQ-029 ball_reset SHALL be high for exactly one cycle per entry into PLAY, and low at all other times.

Reset
REQ-030 While clr_n is low, the block SHALL asynchronously force: state SPLASH; score_1 = score_2 = 0; ball_reset = 0; serve_dir = 0; winner = 0; counters = 0; edge registers = 0.
REQ-031 Reset asserted mid-operation (any state) SHALL abort immediately with no pending ball_reset.
REQ-032 Reset SHALL deassert synchronously at the top level; the first event is accepted on the second clk edge after clr_n rises.

Configuration
REQ-033 Macro GAME_CTRL_AUTO_RESTART_EN, when defined, SHALL add a 10-bit OVER-state frame counter.
REQ-034 With the macro defined, after 4*PAUSE_FRAMES frame_tick pulses in OVER, the block SHALL return to SPLASH as if start had been pressed; a start event still returns to SPLASH earlier.
REQ-035 Without the macro, the OVER counter SHALL be absent and OVER SHALL exit only on a start event or on reset.

Verification
REQ-036 Reset, then start rising -> next edge: cur_state=01, ball_reset=1 for exactly 1 cycle, score_1=score_2=0.
REQ-037 In PLAY, goal_p1 pulse -> score_1=1, serve_dir=1, cur_state=10; after 60 frame_ticks -> cur_state=01 and ball_reset pulse.
REQ-038 goal_p1 held high for 100 cycles in PLAY -> score_1 increments by 1 only.
REQ-039 goal_p1 and goal_p2 rising in the same cycle -> scores unchanged, cur_state=10.
REQ-040 Five player-2 goals (WIN_SCORE=5) -> score_2=5, cur_state=11, winner=1; start -> cur_state=00, scores 0.
REQ-041 clr_n pulled low in POINT with count 30 -> immediate cur_state=00, scores 0; with GAME_CTRL_AUTO_RESTART_EN, OVER plus 240 ticks -> cur_state=00.

Source files
------------

// File: rtl/game_controller.sv
// Pong game sequencer: splash / play / point-pause / game-over, with score keeping.
// Optional GAME_CTRL_AUTO_RESTART_EN returns from OVER to SPLASH after 4*PAUSE_FRAMES frames.
module game_controller #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic       frame_tick,
  output logic [2:0] score_1,
  output logic [2:0] score_2,
  output logic [1:0] cur_state,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       winner
);

  typedef enum logic [1:0] {
    SPLASH = 2'b00,
    PLAY   = 2'b01,
    POINT  = 2'b10,
    OVER   = 2'b11
  } state_t;

  localparam logic [2:0] WIN_VAL   = 3'(WIN_SCORE);
  localparam logic [7:0] PAUSE_VAL = 8'(PAUSE_FRAMES);
`ifdef GAME_CTRL_AUTO_RESTART_EN
  localparam logic [9:0] OVER_VAL  = 10'(4 * PAUSE_FRAMES);
`endif

  // Asserts asynchronously, releases on the first clk edge after clr_n rises.
  logic rst_n_q;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) rst_n_q <= 1'b0;
    else        rst_n_q <= 1'b1;
  end

  state_t     state_q, state_d;
  logic [2:0] score_1_q, score_1_d;
  logic [2:0] score_2_q, score_2_d;
  logic       ball_reset_q, ball_reset_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic [7:0] pause_cnt_q, pause_cnt_d;
  logic       start_q, goal_p1_q, goal_p2_q;
`ifdef GAME_CTRL_AUTO_RESTART_EN
  logic [9:0] over_cnt_q, over_cnt_d;
`endif

  logic       start_ev, p1_ev, p2_ev;
  logic [2:0] score_next;
  logic [7:0] pause_next;

  assign start_ev = start   & ~start_q;
  assign p1_ev    = goal_p1 & ~goal_p1_q;
  assign p2_ev    = goal_p2 & ~goal_p2_q;

  always_comb begin
    state_d      = state_q;
    score_1_d    = score_1_q;
    score_2_d    = score_2_q;
    ball_reset_d = 1'b0;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    pause_cnt_d  = pause_cnt_q;
    score_next   = '0;
    pause_next   = pause_cnt_q + 8'd1;
`ifdef GAME_CTRL_AUTO_RESTART_EN
    over_cnt_d   = over_cnt_q;
`endif

    case (state_q)
      SPLASH: begin
        score_1_d = '0;
        score_2_d = '0;
        if (start_ev) begin
          state_d      = PLAY;
          ball_reset_d = 1'b1;
        end
      end

      PLAY: begin
        // Simultaneous goals are a void rally: pause without scoring.
        if (p1_ev && p2_ev) begin
          state_d     = POINT;
          pause_cnt_d = '0;
        end else if (p1_ev || p2_ev) begin
          score_next  = p1_ev ? score_1_q + 3'd1 : score_2_q + 3'd1;
          serve_dir_d = p1_ev;
          if (p1_ev) score_1_d = score_next;
          else       score_2_d = score_next;
          if (score_next == WIN_VAL) begin
            state_d  = OVER;
            winner_d = p2_ev;
`ifdef GAME_CTRL_AUTO_RESTART_EN
            over_cnt_d = '0;
`endif
          end else begin
            state_d     = POINT;
            pause_cnt_d = '0;
          end
        end
      end

      POINT: begin
        if (frame_tick) begin
          pause_cnt_d = pause_next;
          if (pause_next == PAUSE_VAL) begin
            state_d      = PLAY;
            ball_reset_d = 1'b1;
          end
        end
      end

      OVER: begin
        if (start_ev) begin
          state_d   = SPLASH;
          score_1_d = '0;
          score_2_d = '0;
          winner_d  = 1'b0;
        end
`ifdef GAME_CTRL_AUTO_RESTART_EN
        else if (frame_tick) begin
          over_cnt_d = over_cnt_q + 10'd1;
          if (over_cnt_d == OVER_VAL) begin
            state_d   = SPLASH;
            score_1_d = '0;
            score_2_d = '0;
            winner_d  = 1'b0;
          end
        end
`endif
      end

      default: state_d = SPLASH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q      <= SPLASH;
      score_1_q    <= '0;
      score_2_q    <= '0;
      ball_reset_q <= 1'b0;
      serve_dir_q  <= 1'b0;
      winner_q     <= 1'b0;
      pause_cnt_q  <= '0;
      start_q      <= 1'b0;
      goal_p1_q    <= 1'b0;
      goal_p2_q    <= 1'b0;
`ifdef GAME_CTRL_AUTO_RESTART_EN
      over_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      score_1_q    <= score_1_d;
      score_2_q    <= score_2_d;
      ball_reset_q <= ball_reset_d;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
      pause_cnt_q  <= pause_cnt_d;
      start_q      <= start;
      goal_p1_q    <= goal_p1;
      goal_p2_q    <= goal_p2;
`ifdef GAME_CTRL_AUTO_RESTART_EN
      over_cnt_q   <= over_cnt_d;
`endif
    end
  end

  assign cur_state  = state_q;
  assign score_1    = score_1_q;
  assign score_2    = score_2_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign winner     = winner_q;

endmodule
